sound_frame_sequencer: RTL and testbench

Central timing and trigger controller for the four sound channels (square1, square2, wave, noise). Divides system_clock into a 512 Hz, 8-step frame sequence. Emits single-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) enables in place of per-channel clock dividers. Also sequences channel restart pulses and tracks per-channel active status for the SOUNDCNT_X read-back.

---
 rtl/sound_frame_sequencer_if.sv | 25 ++
 rtl/sound_frame_sequencer.sv | 84 ++++++++
 tb/tb_sound_frame_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sound_frame_sequencer_if.sv
// Control/status bundle between the sound register block and the frame sequencer.
// The master side drives enables and channel events; the slave side is the sequencer.
interface sound_frame_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              master_en;
  logic [NUM_CH-1:0] trigger;
  logic [NUM_CH-1:0] length_expired;
  logic [2:0]        step;
  logic              length_tick;
  logic              sweep_tick;
  logic              env_tick;
  logic [NUM_CH-1:0] ch_restart;
  logic [NUM_CH-1:0] ch_active;

  modport master (
    output master_en, trigger, length_expired,
    input  step, length_tick, sweep_tick, env_tick, ch_restart, ch_active
  );

  modport slave (
    input  master_en, trigger, length_expired,
    output step, length_tick, sweep_tick, env_tick, ch_restart, ch_active
  );
endinterface

// File: rtl/sound_frame_sequencer.sv
// 512 Hz, 8-step frame sequencer issuing length/sweep/envelope enables and channel restarts.
// Define SOUND_SEQ_FAST_SIM_EN to force a divider of 16 for fast simulation.
module sound_frame_sequencer #(
  parameter int DIV    = 32768,
  parameter int NUM_CH = 4
) (
  input  logic                    system_clock,
  input  logic                    reset,
  sound_frame_sequencer_if.slave  bus
);

`ifdef SOUND_SEQ_FAST_SIM_EN
  localparam int EFF_DIV = 16;
`else
  localparam int EFF_DIV = DIV;
`endif
  localparam int PW = (EFF_DIV > 2) ? $clog2(EFF_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(EFF_DIV - 1);

  if (EFF_DIV < 2) begin : g_bad_div
    $error("sound_frame_sequencer: divider must be >= 2");
  end

  logic [PW-1:0]     prescaler;
  logic [2:0]        step;
  logic              en_q;
  logic              length_tick;
  logic              sweep_tick;
  logic              env_tick;
  logic [NUM_CH-1:0] ch_restart;
  logic [NUM_CH-1:0] ch_active;
  logic              step_done;

  // The first edge that samples master_en high only arms the prescaler, so the
  // first step completes DIV+1 edges after enable rather than DIV.
  assign step_done = bus.master_en && en_q && (prescaler == PRE_LAST);

  // NOTE: every register here uses <= so all updates see pre-edge values; a
  // blocking '=' would let step_done and the tick decode race the step update.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      step        <= '0;
      en_q        <= 1'b0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
      ch_restart  <= '0;
      ch_active   <= '0;
    end else begin
      en_q <= bus.master_en;
      if (!bus.master_en) begin
        prescaler   <= '0;
        step        <= '0;
        length_tick <= 1'b0;
        sweep_tick  <= 1'b0;
        env_tick    <= 1'b0;
        ch_restart  <= '0;
        ch_active   <= '0;
      end else begin
        if (en_q) begin
          prescaler <= step_done ? '0 : prescaler + PW'(1);
        end
        if (step_done) begin
          step <= step + 3'd1;
        end
        // Decode uses the step being completed, so the pulse lines up with the new step value.
        length_tick <= step_done && !step[0];
        sweep_tick  <= step_done && (step[1:0] == 2'b10);
        env_tick    <= step_done && (step == 3'd7);
        ch_restart  <= bus.trigger;
        ch_active   <= (ch_active & ~bus.length_expired) | bus.trigger;
      end
    end
  end

  assign bus.step        = step;
  assign bus.length_tick = length_tick;
  assign bus.sweep_tick  = sweep_tick;
  assign bus.env_tick    = env_tick;
  assign bus.ch_restart  = ch_restart;
  assign bus.ch_active   = ch_active;

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Scoreboard bench for sound_frame_sequencer: the driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sound_frame_sequencer;

`ifdef SOUND_SEQ_FAST_SIM_EN
  localparam int D = 16;
`else
  localparam int D = 4;
`endif
  localparam int NCH = 4;

  typedef struct packed {
    logic [2:0]     step;
    logic           length_tick;
    logic           sweep_tick;
    logic           env_tick;
    logic [NCH-1:0] ch_restart;
    logic [NCH-1:0] ch_active;
  } obs_t;

  logic clk;
  logic rst;

  sound_frame_sequencer_if #(.NUM_CH(NCH)) bus ();

  sound_frame_sequencer #(.DIV(4), .NUM_CH(NCH)) dut (
    .system_clock (clk),
    .reset        (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  obs_t exp_q[$];

  // Reference model: position counted in enabled edges since enable/reset.
  int             en_edges = 0;
  logic [NCH-1:0] act_m    = '0;
  obs_t           last_exp = '0;

  function automatic obs_t dut_obs();
    obs_t o;
    o.step        = bus.step;
    o.length_tick = bus.length_tick;
    o.sweep_tick  = bus.sweep_tick;
    o.env_tick    = bus.env_tick;
    o.ch_restart  = bus.ch_restart;
    o.ch_active   = bus.ch_active;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got step=%0d len=%b swp=%b env=%b rst=%b act=%b, required step=%0d len=%b swp=%b env=%b rst=%b act=%b",
               name, $time, got.step, got.length_tick, got.sweep_tick, got.env_tick, got.ch_restart, got.ch_active,
               req.step, req.length_tick, req.sweep_tick, req.env_tick, req.ch_restart, req.ch_active);
    end
  endtask

  function automatic obs_t model_edge(input logic me, input logic [NCH-1:0] trig, input logic [NCH-1:0] expd);
    obs_t e = '0;
    if (!me) begin
      en_edges = 0;
      act_m    = '0;
    end else begin
      int p;
      int s_done;
      bit tick;
      en_edges++;
      p           = en_edges - 1;
      e.step      = 3'((p / D) % 8);
      tick        = (p > 0) && (p % D == 0);
      s_done      = ((p / D) + 7) % 8;
      e.length_tick = tick && (s_done % 2 == 0);
      e.sweep_tick  = tick && (s_done == 2 || s_done == 6);
      e.env_tick    = tick && (s_done == 7);
      e.ch_restart  = trig;
      act_m         = (act_m & ~expd) | trig;
      e.ch_active   = act_m;
    end
    return e;
  endfunction

  task automatic drive(input logic me, input logic [NCH-1:0] trig, input logic [NCH-1:0] expd);
    bus.master_en      = me;
    bus.trigger        = trig;
    bus.length_expired = expd;
    @(posedge clk);
    last_exp = model_edge(me, trig, expd);
    exp_q.push_back(last_exp);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, '0, '0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("cycle", dut_obs(), e);
    end
  end

  initial begin
    int guard;
    rst                = 1'b1;
    bus.master_en      = 1'b0;
    bus.trigger        = '0;
    bus.length_expired = '0;
    #2;
    check("reset_state", dut_obs(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-running tick pattern over more than a full frame.
    idle(10 * D);

    // Two-channel trigger then hold.
    drive(1'b1, 4'b0101, '0);
    idle(3);

    // Expiry versus simultaneous trigger.
    drive(1'b1, 4'b1111, '0);
    drive(1'b1, 4'b0100, 4'b0110);
    idle(2);

    // Power-down mid-step 5 with all channels active.
    drive(1'b1, 4'b1111, '0);
    guard = 0;
    while (last_exp.step != 3'd5 && guard < 20 * D) begin
      idle(1);
      guard++;
    end
    n_cmp++;
    if (last_exp.step != 3'd5) begin
      n_err++;
      $display("FAIL reach_step5: got step=%0d, required 5", last_exp.step);
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) drive(1'b0, 4'($urandom), 4'($urandom));
    idle(3 * D + 2);

    // Randomised traffic with occasional power-downs.
    for (int i = 0; i < 400; i++) begin
      logic           me;
      logic [NCH-1:0] t;
      logic [NCH-1:0] x;
      me = ($urandom_range(0, 59) != 0);
      t  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
      x  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
      drive(me, t, x);
    end

    // Async reset while step=3 and a restart is showing.
    guard = 0;
    while (!(last_exp.step == 3'd3 && ((en_edges - 1) % D) < D - 1) && guard < 20 * D) begin
      idle(1);
      guard++;
    end
    drive(1'b1, 4'b0001, '0);
    n_cmp++;
    if (!(last_exp.step == 3'd3 && last_exp.ch_restart == 4'b0001)) begin
      n_err++;
      $display("FAIL async_precondition: got step=%0d rst=%b, required step=3 rst=0001",
               last_exp.step, last_exp.ch_restart);
    end
    #6;
    rst = 1'b1;
    #1;
    check("async_reset", dut_obs(), '0);
    #1;
    rst      = 1'b0;
    en_edges = 0;
    act_m    = '0;
    idle(2 * D + 3);

    #6;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
